// File: rtl/pir_alarm_controller.sv
// pir_alarm_controller
// Motion alarm sequencer for the PIR buzzer path: synchronizes and debounces
// the raw sensor input, gates it with ARM, and drives a pulsed buzzer pattern
// of fixed length followed by a hold-off before re-arming. Also keeps a
// saturating count of alarm events.
module pir_alarm_controller #(
    parameter int unsigned DEBOUNCE_CYC = 4,
    parameter int unsigned ALARM_CYC    = 16,
    parameter int unsigned BEEP_HALF    = 2,
    parameter int unsigned HOLDOFF_CYC  = 8,
    parameter int unsigned CNT_W        = 16
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       ARM,
    input  logic       ACK,
    input  logic       PIR_IN,
    output logic       BUZZER,
    output logic       ALARM_ACTIVE,
    output logic [1:0] STATE,
    output logic [7:0] EVENT_CNT
);

    typedef enum logic [1:0] {
        ST_DISARMED = 2'd0,
        ST_ARMED    = 2'd1,
        ST_ALARM    = 2'd2,
        ST_HOLDOFF  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] DEB_MAX   = CNT_W'(DEBOUNCE_CYC);
    localparam logic [CNT_W-1:0] ALM_LAST  = CNT_W'(ALARM_CYC - 1);
    localparam logic [CNT_W-1:0] BEEP_LAST = CNT_W'(BEEP_HALF - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLDOFF_CYC - 1);
    localparam logic [7:0]       EVT_MAX   = 8'hFF;

    // Input synchronizer and debounce
    logic             s1_q;
    logic             s2_q;
    logic [CNT_W-1:0] deb_q;
    logic [CNT_W-1:0] deb_d;
    logic             motion;

    // Alarm state machine
    state_t           state_q;
    logic [CNT_W-1:0] tmr_q;
    logic [CNT_W-1:0] beep_q;
    logic             buzzer_q;
    logic             alarm_q;
    logic [7:0]       evt_q;
    logic [7:0]       evt_d;

    // Two-flop synchronizer for the asynchronous sensor pin
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
        end else begin
            s1_q <= PIR_IN;
            s2_q <= s1_q;
        end
    end

    // Debounce next value: clear on a low sample, otherwise count up and hold at the threshold
    always_comb begin
        deb_d = deb_q;
        if (!s2_q) begin
            deb_d = '0;
        end else if (deb_q != DEB_MAX) begin
            deb_d = deb_q + CNT_ONE;
        end
    end

    // Debounce counter register
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            deb_q <= '0;
        end else begin
            deb_q <= deb_d;
        end
    end

    assign motion = (deb_q == DEB_MAX);

    // Saturating event count next value
    always_comb begin
        evt_d = evt_q;
        if (evt_q != EVT_MAX) begin
            evt_d = evt_q + 8'd1;
        end
    end

    // Alarm FSM with registered buzzer/alarm outputs; priority ARM=0 > ACK > expiry > motion
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q  <= ST_DISARMED;
            tmr_q    <= '0;
            beep_q   <= '0;
            buzzer_q <= 1'b0;
            alarm_q  <= 1'b0;
            evt_q    <= '0;
        end else begin
            case (state_q)
                ST_DISARMED: begin
                    buzzer_q <= 1'b0;
                    alarm_q  <= 1'b0;
                    tmr_q    <= '0;
                    beep_q   <= '0;
                    if (ARM) begin
                        state_q <= ST_ARMED;
                    end
                end

                ST_ARMED: begin
                    tmr_q  <= '0;
                    beep_q <= '0;
                    if (!ARM) begin
                        state_q  <= ST_DISARMED;
                        buzzer_q <= 1'b0;
                        alarm_q  <= 1'b0;
                    end else if (motion) begin
                        state_q  <= ST_ALARM;
                        buzzer_q <= 1'b1;
                        alarm_q  <= 1'b1;
                        evt_q    <= evt_d;
                    end
                end

                ST_ALARM: begin
                    if (!ARM) begin
                        state_q  <= ST_DISARMED;
                        buzzer_q <= 1'b0;
                        alarm_q  <= 1'b0;
                        tmr_q    <= '0;
                        beep_q   <= '0;
                    end else if (ACK || (tmr_q == ALM_LAST)) begin
                        state_q  <= ST_HOLDOFF;
                        buzzer_q <= 1'b0;
                        alarm_q  <= 1'b0;
                        tmr_q    <= '0;
                        beep_q   <= '0;
                    end else begin
                        tmr_q <= tmr_q + CNT_ONE;
                        if (beep_q == BEEP_LAST) begin
                            buzzer_q <= ~buzzer_q;
                            beep_q   <= '0;
                        end else begin
                            beep_q <= beep_q + CNT_ONE;
                        end
                    end
                end

                ST_HOLDOFF: begin
                    buzzer_q <= 1'b0;
                    alarm_q  <= 1'b0;
                    beep_q   <= '0;
                    if (!ARM) begin
                        state_q <= ST_DISARMED;
                        tmr_q   <= '0;
                    end else if (tmr_q == HOLD_LAST) begin
                        state_q <= ST_ARMED;
                        tmr_q   <= '0;
                    end else begin
                        tmr_q <= tmr_q + CNT_ONE;
                    end
                end

                default: begin
                    state_q  <= ST_DISARMED;
                    buzzer_q <= 1'b0;
                    alarm_q  <= 1'b0;
                    tmr_q    <= '0;
                    beep_q   <= '0;
                end
            endcase
        end
    end

    assign STATE        = state_q;
    assign BUZZER       = buzzer_q;
    assign ALARM_ACTIVE = alarm_q;
    assign EVENT_CNT    = evt_q;

endmodule

// File: tb/tb_pir_alarm_controller.sv
// Directed testbench for pir_alarm_controller with default parameters.
module tb_pir_alarm_controller;

    logic       CLK;
    logic       RST;
    logic       ARM;
    logic       ACK;
    logic       PIR_IN;
    logic       BUZZER;
    logic       ALARM_ACTIVE;
    logic [1:0] STATE;
    logic [7:0] EVENT_CNT;

    int checks = 0;
    int errors = 0;

    pir_alarm_controller #(
        .DEBOUNCE_CYC(4),
        .ALARM_CYC(16),
        .BEEP_HALF(2),
        .HOLDOFF_CYC(8),
        .CNT_W(16)
    ) dut (
        .CLK(CLK),
        .RST(RST),
        .ARM(ARM),
        .ACK(ACK),
        .PIR_IN(PIR_IN),
        .BUZZER(BUZZER),
        .ALARM_ACTIVE(ALARM_ACTIVE),
        .STATE(STATE),
        .EVENT_CNT(EVENT_CNT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Advance one rising edge and settle 1 time unit past it
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        RST    = 1'b1;
        ARM    = 1'b0;
        ACK    = 1'b0;
        PIR_IN = 1'b0;

        // Reset state
        tick();
        tick();
        chk("rst_state", 32'(STATE), 32'd0);
        chk("rst_buzzer", 32'(BUZZER), 32'd0);
        chk("rst_active", 32'(ALARM_ACTIVE), 32'd0);
        chk("rst_evt", 32'(EVENT_CNT), 32'd0);

        // Release and arm
        RST = 1'b0;
        ARM = 1'b1;
        chk("rel_state_hold", 32'(STATE), 32'd0);
        tick();
        chk("armed", 32'(STATE), 32'd1);

        // Full alarm cycle: PIR high from edge 0, ALARM after edge 6
        PIR_IN = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        chk("lat_edge5_state", 32'(STATE), 32'd1);
        chk("lat_edge5_buzzer", 32'(BUZZER), 32'd0);
        tick();
        chk("lat_edge6_state", 32'(STATE), 32'd2);
        chk("lat_edge6_active", 32'(ALARM_ACTIVE), 32'd1);
        chk("evt1", 32'(EVENT_CNT), 32'd1);
        for (int k = 0; k < 16; k++) begin
            chk("alarm_state", 32'(STATE), 32'd2);
            chk("beep_pattern", 32'(BUZZER), ((k / 2) % 2 == 0) ? 32'd1 : 32'd0);
            tick();
        end
        for (int h = 0; h < 8; h++) begin
            chk("holdoff_state", 32'(STATE), 32'd3);
            chk("holdoff_buzzer", 32'(BUZZER), 32'd0);
            chk("holdoff_active", 32'(ALARM_ACTIVE), 32'd0);
            tick();
        end
        chk("rearm_state", 32'(STATE), 32'd1);
        chk("rearm_evt", 32'(EVENT_CNT), 32'd1);
        tick();
        chk("retrig_state", 32'(STATE), 32'd2);
        chk("evt2", 32'(EVENT_CNT), 32'd2);
        chk("retrig_buzzer", 32'(BUZZER), 32'd1);

        // ACK in 5th alarm cycle
        for (int i = 0; i < 4; i++) tick();
        chk("pre_ack_state", 32'(STATE), 32'd2);
        chk("pre_ack_buzzer", 32'(BUZZER), 32'd1);
        ACK    = 1'b1;
        PIR_IN = 1'b0;
        tick();
        ACK = 1'b0;
        chk("ack_state", 32'(STATE), 32'd3);
        chk("ack_buzzer", 32'(BUZZER), 32'd0);
        chk("ack_active", 32'(ALARM_ACTIVE), 32'd0);
        for (int i = 0; i < 7; i++) tick();
        chk("ack_hold7", 32'(STATE), 32'd3);
        tick();
        chk("ack_rearm", 32'(STATE), 32'd1);
        chk("ack_evt", 32'(EVENT_CNT), 32'd2);

        // Glitch rejection: 3 cycles high then low
        PIR_IN = 1'b1;
        tick();
        tick();
        tick();
        PIR_IN = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("glitch_state", 32'(STATE), 32'd1);
            chk("glitch_buzzer", 32'(BUZZER), 32'd0);
        end
        chk("glitch_evt", 32'(EVENT_CNT), 32'd2);

        // Disarm, then PIR high while disarmed
        ARM = 1'b0;
        tick();
        chk("disarm_state", 32'(STATE), 32'd0);
        PIR_IN = 1'b1;
        for (int i = 0; i < 8; i++) tick();
        chk("disarmed_pir_state", 32'(STATE), 32'd0);
        chk("disarmed_pir_buzzer", 32'(BUZZER), 32'd0);
        chk("disarmed_pir_evt", 32'(EVENT_CNT), 32'd2);
        ARM = 1'b1;
        tick();
        chk("arm_with_motion", 32'(STATE), 32'd1);
        tick();
        chk("arm_motion_alarm", 32'(STATE), 32'd2);
        chk("evt3", 32'(EVENT_CNT), 32'd3);

        // ARM=0 together with ACK in ALARM -> DISARMED
        tick();
        tick();
        ARM = 1'b0;
        ACK = 1'b1;
        tick();
        ACK = 1'b0;
        chk("disarm_ack_state", 32'(STATE), 32'd0);
        chk("disarm_ack_buzzer", 32'(BUZZER), 32'd0);
        chk("disarm_ack_active", 32'(ALARM_ACTIVE), 32'd0);

        // Asynchronous reset mid-ALARM
        ARM = 1'b1;
        tick();
        chk("rst_pre_armed", 32'(STATE), 32'd1);
        tick();
        chk("rst_pre_alarm", 32'(STATE), 32'd2);
        chk("evt4", 32'(EVENT_CNT), 32'd4);
        tick();
        chk("rst_pre_buzzer", 32'(BUZZER), 32'd1);
        #2;
        RST = 1'b1;
        #1;
        chk("async_rst_buzzer", 32'(BUZZER), 32'd0);
        chk("async_rst_active", 32'(ALARM_ACTIVE), 32'd0);
        chk("async_rst_state", 32'(STATE), 32'd0);
        chk("async_rst_evt", 32'(EVENT_CNT), 32'd0);
        tick();
        tick();
        chk("rst_held_state", 32'(STATE), 32'd0);
        RST = 1'b0;
        chk("rst_rel_state", 32'(STATE), 32'd0);
        tick();
        chk("rst_rel_armed", 32'(STATE), 32'd1);

        // Saturation: drive events past 255 via fast disarm/re-arm loops
        for (int i = 0; i < 20 && STATE != 2'd2; i++) tick();
        chk("sat_first_alarm", 32'(STATE), 32'd2);
        chk("sat_evt1", 32'(EVENT_CNT), 32'd1);
        for (int i = 0; i < 259; i++) begin
            ARM = 1'b0;
            tick();
            ARM = 1'b1;
            tick();
            tick();
            if (i == 252) chk("sat_evt254", 32'(EVENT_CNT), 32'd254);
            if (i == 253) chk("sat_evt255", 32'(EVENT_CNT), 32'd255);
        end
        chk("sat_final_state", 32'(STATE), 32'd2);
        chk("sat_final_evt", 32'(EVENT_CNT), 32'd255);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
